// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
// Module   : alu_ctrl_pkg
// Brief    : ALU signal codes, MIPS opcode/funct encodings, issue FSM states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

    localparam logic [3:0] c_SIG_AND   = 4'd0;
    localparam logic [3:0] c_SIG_OR    = 4'd1;
    localparam logic [3:0] c_SIG_ADD   = 4'd2;
    localparam logic [3:0] c_SIG_SLL   = 4'd3;
    localparam logic [3:0] c_SIG_SRL   = 4'd4;
    localparam logic [3:0] c_SIG_MFHI  = 4'd5;
    localparam logic [3:0] c_SIG_SUB   = 4'd6;
    localparam logic [3:0] c_SIG_SLT   = 4'd7;
    localparam logic [3:0] c_SIG_MFLO  = 4'd8;
    localparam logic [3:0] c_SIG_MULTU = 4'd9;

    localparam logic [5:0] c_OP_RTYPE  = 6'h00;
    localparam logic [5:0] c_OP_ADDIU  = 6'h09;
    localparam logic [5:0] c_OP_ORI    = 6'h0D;

    localparam logic [5:0] c_FN_SLL    = 6'h00;
    localparam logic [5:0] c_FN_SRL    = 6'h02;
    localparam logic [5:0] c_FN_MFHI   = 6'h10;
    localparam logic [5:0] c_FN_MFLO   = 6'h12;
    localparam logic [5:0] c_FN_MULTU  = 6'h19;
    localparam logic [5:0] c_FN_ADDU   = 6'h21;
    localparam logic [5:0] c_FN_SUBU   = 6'h23;
    localparam logic [5:0] c_FN_AND    = 6'h24;
    localparam logic [5:0] c_FN_OR     = 6'h25;
    localparam logic [5:0] c_FN_SLT    = 6'h2A;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        MBUSY = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ex_decode.sv
// ============================================================================
// Module   : ex_decode
// Brief    : Combinational MIPS decode into ALU signal code and operands A/B.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_decode
    import alu_ctrl_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [5:0]    i_opcode,
    input  logic [5:0]    i_funct,
    input  logic [4:0]    i_shamt,
    input  logic [15:0]   i_imm,
    input  logic [DW-1:0] i_rs_data,
    input  logic [DW-1:0] i_rt_data,
    output logic [3:0]    o_signal,
    output logic [DW-1:0] o_a,
    output logic [DW-1:0] o_b,
    output logic          o_illegal,
    output logic          o_is_hilo_op
);

    always_comb begin
        o_signal     = c_SIG_AND;
        o_a          = i_rs_data;
        o_b          = i_rt_data;
        o_illegal    = 1'b0;
        o_is_hilo_op = 1'b0;
        case (i_opcode)
            c_OP_RTYPE: begin
                case (i_funct)
                    c_FN_AND:  o_signal = c_SIG_AND;
                    c_FN_OR:   o_signal = c_SIG_OR;
                    c_FN_ADDU: o_signal = c_SIG_ADD;
                    c_FN_SUBU: o_signal = c_SIG_SUB;
                    c_FN_SLT:  o_signal = c_SIG_SLT;
                    c_FN_SLL, c_FN_SRL: begin
                        o_signal = (i_funct == c_FN_SLL) ? c_SIG_SLL : c_SIG_SRL;
                        o_a      = i_rt_data;
                        o_b      = {{(DW-5){1'b0}}, i_shamt};
                    end
                    c_FN_MFHI, c_FN_MFLO: begin
                        o_signal     = (i_funct == c_FN_MFHI) ? c_SIG_MFHI : c_SIG_MFLO;
                        o_a          = '0;
                        o_b          = '0;
                        o_is_hilo_op = 1'b1;
                    end
                    c_FN_MULTU: begin
                        o_signal     = c_SIG_MULTU;
                        o_is_hilo_op = 1'b1;
                    end
                    default: begin
                        o_a       = '0;
                        o_b       = '0;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            c_OP_ADDIU: begin
                o_signal = c_SIG_ADD;
                o_b      = {{(DW-16){i_imm[15]}}, i_imm};
            end
            c_OP_ORI: begin
                o_signal = c_SIG_OR;
                o_b      = {{(DW-16){1'b0}}, i_imm};
            end
            default: begin
                o_a       = '0;
                o_b       = '0;
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ex_issue_ctrl.sv
// ============================================================================
// Module   : ex_issue_ctrl
// Brief    : Execute-stage issue slot with multiply-busy hazard stall.
//            Optional EX_STALL_CNT_EN adds a saturating stall_cnt output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 32,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    input  logic [5:0]    opcode,
    input  logic [5:0]    funct,
    input  logic [4:0]    shamt,
    input  logic [15:0]   imm,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    output logic [3:0]    alu_signal,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic          out_valid,
    output logic          illegal,
`ifdef EX_STALL_CNT_EN
    output logic          mult_busy,
    output logic [31:0]   stall_cnt
`else
    output logic          mult_busy
`endif
);

    localparam int             c_CW       = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(MULT_LAT - 1);

    logic [3:0]    w_signal;
    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;
    logic          w_illegal;
    logic          w_is_hilo;
    logic          w_take;
    logic          w_start_mult;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;

    logic [3:0]    r_alu_signal;
    logic [DW-1:0] r_alu_a;
    logic [DW-1:0] r_alu_b;
    logic          r_out_valid;
    logic          r_illegal;

    ex_decode #(
        .DW (DW)
    ) u_decode (
        .i_opcode     (opcode),
        .i_funct      (funct),
        .i_shamt      (shamt),
        .i_imm        (imm),
        .i_rs_data    (rs_data),
        .i_rt_data    (rt_data),
        .o_signal     (w_signal),
        .o_a          (w_a),
        .o_b          (w_b),
        .o_illegal    (w_illegal),
        .o_is_hilo_op (w_is_hilo)
    );

    assign mult_busy    = (r_state == MBUSY);
    assign in_ready     = !(mult_busy && in_valid && w_is_hilo);
    // A flushed acceptance is dropped entirely, including any multiply start.
    assign w_take       = in_valid && in_ready && !flush;
    assign w_start_mult = w_take && (w_signal == c_SIG_MULTU);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_start_mult) begin
                    w_state_nxt = MBUSY;
                    w_cnt_nxt   = c_CNT_LOAD;
                end
            end
            MBUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_alu_signal <= c_SIG_AND;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_out_valid  <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_out_valid <= w_take;
            r_illegal   <= w_take && w_illegal;
            if (w_take) begin
                r_alu_signal <= w_signal;
                r_alu_a      <= w_a;
                r_alu_b      <= w_b;
            end
        end
    end

    assign alu_signal = r_alu_signal;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign out_valid  = r_out_valid;
    assign illegal    = r_illegal;

`ifdef EX_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (in_valid && !in_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_issue_ctrl.sv
// ============================================================================
// Module   : tb_ex_issue_ctrl
// Brief    : Directed + random bench for ex_issue_ctrl at MULT_LAT 4 and 32.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ex_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        iv    [2];
    logic        fl    [2];
    logic [5:0]  op    [2];
    logic [5:0]  fn    [2];
    logic [4:0]  sh    [2];
    logic [15:0] im    [2];
    logic [31:0] rs    [2];
    logic [31:0] rt    [2];
    logic        rdy   [2];
    logic [3:0]  sig   [2];
    logic [31:0] a     [2];
    logic [31:0] b     [2];
    logic        ov    [2];
    logic        ill   [2];
    logic        busy  [2];
    logic [31:0] scnt  [2];

    int          total = 0;
    int          bad   = 0;

    int          lat    [2] = '{4, 32};
    int          m_left [2];
    logic        m_ov   [2];
    logic        m_ill  [2];
    logic [3:0]  m_sig  [2];
    logic [31:0] m_a    [2];
    logic [31:0] m_b    [2];
    logic [31:0] m_scnt [2];
    logic        d_rdy  [2];
    logic        d_busy [2];

    always #5 clk = ~clk;

    ex_issue_ctrl #(.MULT_LAT(4), .DW(32)) u_dut0 (
        .clk(clk), .reset(rst_n[0]), .in_valid(iv[0]), .in_ready(rdy[0]), .flush(fl[0]),
        .opcode(op[0]), .funct(fn[0]), .shamt(sh[0]), .imm(im[0]),
        .rs_data(rs[0]), .rt_data(rt[0]), .alu_signal(sig[0]), .alu_a(a[0]), .alu_b(b[0]),
        .out_valid(ov[0]), .illegal(ill[0]),
`ifdef EX_STALL_CNT_EN
        .mult_busy(busy[0]), .stall_cnt(scnt[0])
`else
        .mult_busy(busy[0])
`endif
    );

    ex_issue_ctrl #(.MULT_LAT(32), .DW(32)) u_dut1 (
        .clk(clk), .reset(rst_n[1]), .in_valid(iv[1]), .in_ready(rdy[1]), .flush(fl[1]),
        .opcode(op[1]), .funct(fn[1]), .shamt(sh[1]), .imm(im[1]),
        .rs_data(rs[1]), .rt_data(rt[1]), .alu_signal(sig[1]), .alu_a(a[1]), .alu_b(b[1]),
        .out_valid(ov[1]), .illegal(ill[1]),
`ifdef EX_STALL_CNT_EN
        .mult_busy(busy[1]), .stall_cnt(scnt[1])
`else
        .mult_busy(busy[1])
`endif
    );

`ifndef EX_STALL_CNT_EN
    assign scnt[0] = 32'd0;
    assign scnt[1] = 32'd0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode written straight from the instruction table.
    task automatic ref_decode(input logic [5:0] o, input logic [5:0] f, input logic [4:0] s,
                              input logic [15:0] i, input logic [31:0] rsv, input logic [31:0] rtv,
                              output logic [3:0] sg, output logic [31:0] av, output logic [31:0] bv,
                              output logic il, output logic hl);
        sg = 4'd0; av = rsv; bv = rtv; il = 1'b0; hl = 1'b0;
        if (o == 6'h09) begin
            sg = 4'd2; bv = {{16{i[15]}}, i};
        end else if (o == 6'h0D) begin
            sg = 4'd1; bv = {16'd0, i};
        end else if (o != 6'h00) begin
            il = 1'b1; av = 0; bv = 0;
        end else begin
            case (f)
                6'h24: sg = 4'd0;
                6'h25: sg = 4'd1;
                6'h21: sg = 4'd2;
                6'h23: sg = 4'd6;
                6'h2A: sg = 4'd7;
                6'h00: begin sg = 4'd3; av = rtv; bv = {27'd0, s}; end
                6'h02: begin sg = 4'd4; av = rtv; bv = {27'd0, s}; end
                6'h10: begin sg = 4'd5; av = 0; bv = 0; hl = 1'b1; end
                6'h12: begin sg = 4'd8; av = 0; bv = 0; hl = 1'b1; end
                6'h19: begin sg = 4'd9; hl = 1'b1; end
                default: begin il = 1'b1; av = 0; bv = 0; end
            endcase
        end
    endtask

    task automatic step();
        logic [3:0]  sg;
        logic [31:0] av, bv;
        logic        il, hl, eb, er, take;
        #1;
        for (int k = 0; k < 2; k++) begin
            ref_decode(op[k], fn[k], sh[k], im[k], rs[k], rt[k], sg, av, bv, il, hl);
            eb = (m_left[k] > 0);
            er = !(eb && iv[k] && hl);
            check($sformatf("mult_busy%0d", k), {31'd0, busy[k]}, {31'd0, eb});
            check($sformatf("in_ready%0d", k), {31'd0, rdy[k]}, {31'd0, er});
            d_rdy[k]  = rdy[k];
            d_busy[k] = busy[k];
            take = iv[k] && er && !fl[k];
            if (!rst_n[k]) begin
                m_left[k] = 0; m_ov[k] = 1'b0; m_ill[k] = 1'b0;
                m_sig[k] = 4'd0; m_a[k] = 0; m_b[k] = 0; m_scnt[k] = 0;
            end else begin
                if (iv[k] && !er && m_scnt[k] != 32'hFFFF_FFFF) m_scnt[k]++;
                if (m_left[k] > 0) m_left[k]--;
                if (take && sg == 4'd9) m_left[k] = lat[k];
                m_ov[k]  = take;
                m_ill[k] = take && il;
                if (take) begin
                    m_sig[k] = sg; m_a[k] = av; m_b[k] = bv;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("out_valid%0d", k), {31'd0, ov[k]}, {31'd0, m_ov[k]});
            check($sformatf("illegal%0d", k), {31'd0, ill[k]}, {31'd0, m_ill[k]});
            if (m_ov[k]) begin
                check($sformatf("alu_signal%0d", k), {28'd0, sig[k]}, {28'd0, m_sig[k]});
                check($sformatf("alu_a%0d", k), a[k], m_a[k]);
                check($sformatf("alu_b%0d", k), b[k], m_b[k]);
            end
`ifdef EX_STALL_CNT_EN
            check($sformatf("stall_cnt%0d", k), scnt[k], m_scnt[k]);
`endif
        end
    endtask

    task automatic set_op(input int k, input logic [5:0] o, input logic [5:0] f, input logic [4:0] s,
                          input logic [15:0] i, input logic [31:0] r1, input logic [31:0] r2);
        iv[k] = 1'b1; fl[k] = 1'b0;
        op[k] = o; fn[k] = f; sh[k] = s; im[k] = i; rs[k] = r1; rt[k] = r2;
    endtask

    task automatic idle(input int k);
        iv[k] = 1'b0; fl[k] = 1'b0;
    endtask

    task automatic rand_op(input int k);
        logic [5:0] fl_tab [10];
        int         r;
        fl_tab = '{6'h24, 6'h25, 6'h21, 6'h23, 6'h2A, 6'h00, 6'h02, 6'h10, 6'h12, 6'h19};
        r = $urandom_range(0, 13);
        set_op(k, 6'h00, fl_tab[0], 5'($urandom), 16'($urandom), $urandom, $urandom);
        if (r < 10)       fn[k] = fl_tab[r];
        else if (r == 10) op[k] = 6'h09;
        else if (r == 11) op[k] = 6'h0D;
        else if (r == 12) fn[k] = 6'h3F;
        else              op[k] = 6'h3F;
        iv[k] = ($urandom_range(0, 4) != 0);
    endtask

    initial begin
        int n, nb;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; idle(k);
            op[k] = 0; fn[k] = 0; sh[k] = 0; im[k] = 0; rs[k] = 0; rt[k] = 0;
            m_left[k] = 0; m_ov[k] = 0; m_ill[k] = 0; m_sig[k] = 0;
            m_a[k] = 0; m_b[k] = 0; m_scnt[k] = 0; d_rdy[k] = 1'b1; d_busy[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_signal", {28'd0, sig[k]}, 32'd0);
            check("rst_a", a[k], 32'd0);
            check("rst_b", b[k], 32'd0);
            check("rst_valid", {31'd0, ov[k]}, 32'd0);
            check("rst_busy", {31'd0, busy[k]}, 32'd0);
            rst_n[k] = 1'b1;
        end

        set_op(0, 6'h00, 6'h21, 5'd0, 16'd0, 32'd5, 32'd7); step();
        check("add_sig", {28'd0, sig[0]}, 32'd2);
        check("add_a", a[0], 32'd5);
        check("add_b", b[0], 32'd7);
        check("add_valid", {31'd0, ov[0]}, 32'd1);
        set_op(0, 6'h09, 6'h00, 5'd0, 16'hFFFE, 32'd10, 32'd0); step();
        check("addiu_b", b[0], 32'hFFFF_FFFE);
        set_op(0, 6'h00, 6'h00, 5'd4, 16'd0, 32'd99, 32'd3); step();
        check("sll_sig", {28'd0, sig[0]}, 32'd3);
        check("sll_a", a[0], 32'd3);
        check("sll_b", b[0], 32'd4);

        // multu then held mflo: stalled for exactly MULT_LAT cycles
        set_op(0, 6'h00, 6'h19, 5'd0, 16'd0, 32'd3, 32'd4); step();
        set_op(0, 6'h00, 6'h12, 5'd0, 16'd0, 32'd0, 32'd0);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (d_rdy[0]) break;
            n++;
        end
        check("mflo_stall", n, 32'd4);
        check("mflo_sig", {28'd0, sig[0]}, 32'd8);
        set_op(0, 6'h00, 6'h19, 5'd0, 16'd0, 32'd1, 32'd2); step();
        set_op(0, 6'h00, 6'h21, 5'd0, 16'd0, 32'd1, 32'd1); step();
        check("add_in_mbusy_ready", {31'd0, d_rdy[0]}, 32'd1);
        check("add_in_mbusy_busy", {31'd0, d_busy[0]}, 32'd1);
        idle(0); repeat (4) step();

        // back-to-back multu at MULT_LAT = 32
        set_op(1, 6'h00, 6'h19, 5'd0, 16'd0, 32'd6, 32'd7); step();
        n = 0; nb = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (d_busy[1]) nb++;
            if (d_rdy[1]) break;
            n++;
        end
        check("multu2_stall", n, 32'd32);
        idle(1);
        for (int c = 0; c < 60; c++) begin
            step();
            if (!d_busy[1]) break;
            nb++;
        end
        check("busy_total", nb, 32'd64);

        set_op(0, 6'h00, 6'h3F, 5'd0, 16'd0, 32'd11, 32'd12); step();
        check("illegal_flag", {31'd0, ill[0]}, 32'd1);
        check("illegal_sig", {28'd0, sig[0]}, 32'd0);
        set_op(0, 6'h00, 6'h19, 5'd0, 16'd0, 32'd1, 32'd1); fl[0] = 1'b1; step();
        check("flush_valid", {31'd0, ov[0]}, 32'd0);
        idle(0); step();
        check("flush_no_busy", {31'd0, d_busy[0]}, 32'd0);

        // reset during cycle 10 of a 32-cycle multiply
        set_op(1, 6'h00, 6'h19, 5'd0, 16'd0, 32'd2, 32'd2); step();
        idle(1); repeat (9) step();
        rst_n[1] = 1'b0; step();
        check("rst_mid_busy", {31'd0, busy[1]}, 32'd0);
        check("rst_mid_valid", {31'd0, ov[1]}, 32'd0);
`ifdef EX_STALL_CNT_EN
        check("rst_stall_cnt", scnt[1], 32'd0);
`endif
        rst_n[1] = 1'b1;
        set_op(1, 6'h00, 6'h10, 5'd0, 16'd0, 32'd0, 32'd0); step();
        check("mfhi_after_rst", {31'd0, d_rdy[1]}, 32'd1);
        check("mfhi_sig", {28'd0, sig[1]}, 32'd5);

        // random traffic; stalled instructions are held by the source
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!(iv[k] && !d_rdy[k])) rand_op(k);
                fl[k]    = ($urandom_range(0, 9) == 0);
                rst_n[k] = ($urandom_range(0, 299) != 0);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
